// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  typedef logic [1:0] kp_idx_t;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    WAIT_RELEASE
  } kp_state_t;

  // One-hot active-low column drive for a column index.
  function automatic logic [KP_COLS-1:0] col_drive(input kp_idx_t idx);
    return ~(KP_COLS'(1) << idx);
  endfunction

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [KP_ROWS-1:0] rows);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KP_ROWS; i++) begin
      if (!rows[i]) n++;
    end
    return (n == 1);
  endfunction

  // Index of the (lowest) row line that is low.
  function automatic kp_idx_t low_index(input logic [KP_ROWS-1:0] rows);
    kp_idx_t idx;
    idx = '0;
    for (int i = KP_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = kp_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the accepted-key report bus towards the digit decoder.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KP_ROWS-1:0] row_i;
  logic [KP_COLS-1:0] col_o;
  logic               dato_listo_o;
  kp_idx_t            dato_codc_o;
  kp_idx_t            dato_codf_o;
  logic               key_held_o;

  modport master (
    input  row_i,
    output col_o, dato_listo_o, dato_codc_o, dato_codf_o, key_held_o
  );

  modport slave (
    output row_i,
    input  col_o, dato_listo_o, dato_codc_o, dato_codf_o, key_held_o
  );

endinterface

// File: rtl/keypad_sync.sv
// Parameterised-width two-flop synchroniser; resets to all ones (rows idle high).
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, row debounce, one pulse per accepted key.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 50_000,
  parameter int unsigned DEB_CYCLES    = 500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int unsigned MAX_P =
    (SCAN_DIV > DEB_CYCLES) ?
      ((SCAN_DIV > REPEAT_CYCLES) ? SCAN_DIV : REPEAT_CYCLES) :
      ((DEB_CYCLES > REPEAT_CYCLES) ? DEB_CYCLES : REPEAT_CYCLES);
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  logic [KP_ROWS-1:0] rows_s;

  kp_state_t          state, state_n;
  kp_idx_t            col_idx, col_idx_n;
  kp_idx_t            row_idx, row_idx_n;
  logic [KP_ROWS-1:0] row_pat, row_pat_n;
  logic [CNT_W-1:0]   scan_cnt, scan_cnt_n;
  logic [CNT_W-1:0]   deb_cnt, deb_cnt_n;
  logic [KP_COLS-1:0] col_q, col_n;
  logic               listo_q, listo_n;
  kp_idx_t            codc_q, codc_n;
  kp_idx_t            codf_q, codf_n;
  logic               held_q, held_n;
  logic               advance;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CNT_W-1:0]   rep_cnt, rep_cnt_n;
`endif

  keypad_sync #(.WIDTH(KP_ROWS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.row_i),
    .q   (rows_s)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SCAN;
      col_idx  <= '0;
      row_idx  <= '0;
      row_pat  <= '1;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      col_q    <= col_drive(kp_idx_t'(0));
      listo_q  <= 1'b0;
      codc_q   <= '0;
      codf_q   <= '0;
      held_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      col_idx  <= col_idx_n;
      row_idx  <= row_idx_n;
      row_pat  <= row_pat_n;
      scan_cnt <= scan_cnt_n;
      deb_cnt  <= deb_cnt_n;
      col_q    <= col_n;
      listo_q  <= listo_n;
      codc_q   <= codc_n;
      codf_q   <= codf_n;
      held_q   <= held_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt  <= rep_cnt_n;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    col_idx_n  = col_idx;
    row_idx_n  = row_idx;
    row_pat_n  = row_pat;
    scan_cnt_n = scan_cnt;
    deb_cnt_n  = deb_cnt;
    col_n      = col_q;
    listo_n    = 1'b0;
    codc_n     = codc_q;
    codf_n     = codf_q;
    held_n     = held_q;
    advance    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_n  = rep_cnt;
`endif

    case (state)
      SCAN: begin
        if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
          scan_cnt_n = '0;
          if (single_low(rows_s)) begin
            row_idx_n = low_index(rows_s);
            row_pat_n = rows_s;
            deb_cnt_n = '0;
            state_n   = DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end else begin
          scan_cnt_n = scan_cnt + CNT_W'(1);
        end
      end

      DEBOUNCE: begin
        if (rows_s == row_pat) begin
          if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            state_n = PRESSED;
            listo_n = 1'b1;
            codc_n  = col_idx;
            codf_n  = row_idx;
          end else begin
            deb_cnt_n = deb_cnt + CNT_W'(1);
          end
        end else begin
          state_n = SCAN;
          advance = 1'b1;
        end
      end

      PRESSED: begin
        held_n    = 1'b1;
        deb_cnt_n = '0;
        state_n   = WAIT_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_n = CNT_W'(1);
`endif
      end

      WAIT_RELEASE: begin
        if (rows_s == '1) begin
          if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            held_n    = 1'b0;
            deb_cnt_n = '0;
            state_n   = SCAN;
            advance   = 1'b1;
          end else begin
            deb_cnt_n = deb_cnt + CNT_W'(1);
          end
        end else begin
          deb_cnt_n = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Period counted from the previous pulse; only the original key keeps it running.
        if (rows_s == row_pat) begin
          if (rep_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
            listo_n   = 1'b1;
            rep_cnt_n = '0;
          end else begin
            rep_cnt_n = rep_cnt + CNT_W'(1);
          end
        end else begin
          rep_cnt_n = '0;
        end
`endif
      end

      default: state_n = SCAN;
    endcase

    if (advance) begin
      col_idx_n = col_idx + kp_idx_t'(1);
      col_n     = col_drive(col_idx + kp_idx_t'(1));
    end
  end

  assign kp.col_o        = col_q;
  assign kp.dato_listo_o = listo_q;
  assign kp.dato_codc_o  = codc_q;
  assign kp.dato_codf_o  = codf_q;
  assign kp.key_held_o   = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int unsigned SCAN_DIV      = 4;
  localparam int unsigned DEB_CYCLES    = 8;
  localparam int unsigned REPEAT_CYCLES = 32;

  logic clk;
  logic rst;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEB_CYCLES    (DEB_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low.
  logic    key_dn [2];
  kp_idx_t key_c  [2];
  kp_idx_t key_r  [2];
  logic [3:0] row_drv;

  always_comb begin
    row_drv = 4'hF;
    for (int k = 0; k < 2; k++) begin
      if (key_dn[k] && !kp.col_o[key_c[k]]) row_drv[key_r[k]] = 1'b0;
    end
  end
  assign kp.row_i = row_drv;

  // Pulse monitor.
  int      cyc;
  int      ts_q [$];
  kp_idx_t pc_q [$];
  kp_idx_t pr_q [$];

  initial cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (kp.dato_listo_o) begin
      ts_q.push_back(cyc);
      pc_q.push_back(kp.dato_codc_o);
      pr_q.push_back(kp.dato_codf_o);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (kp.dato_listo_o) ok = 1'b1;
    end
  endtask

  task automatic wait_release(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (!kp.key_held_o) ok = 1'b1;
    end
  endtask

  typedef struct {
    kp_idx_t    c;
    kp_idx_t    r;
    logic [1:0] exp_c;
    logic [1:0] exp_r;
    logic [3:0] exp_col_after;
  } press_t;

  press_t     presses [4];
  logic [3:0] idle_col [20];

  initial begin
    bit         ok;
    int         n0;
    int         run;
    logic [3:0] seen;

    presses[0] = '{c: 2'd2, r: 2'd2, exp_c: 2'd2, exp_r: 2'd2, exp_col_after: 4'b0111};
    presses[1] = '{c: 2'd0, r: 2'd3, exp_c: 2'd0, exp_r: 2'd3, exp_col_after: 4'b1101};
    presses[2] = '{c: 2'd3, r: 2'd1, exp_c: 2'd3, exp_r: 2'd1, exp_col_after: 4'b1110};
    presses[3] = '{c: 2'd1, r: 2'd0, exp_c: 2'd1, exp_r: 2'd0, exp_col_after: 4'b1011};
    for (int i = 0; i < 20; i++) begin
      case (i / 4)
        0: idle_col[i] = 4'b1110;
        1: idle_col[i] = 4'b1101;
        2: idle_col[i] = 4'b1011;
        3: idle_col[i] = 4'b0111;
        default: idle_col[i] = 4'b1110;
      endcase
    end

    for (int k = 0; k < 2; k++) begin
      key_dn[k] = 1'b0;
      key_c[k]  = '0;
      key_r[k]  = '0;
    end

    // Reset values.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    step();
    check("reset_col", int'(kp.col_o), 4'b1110);
    check("reset_listo", int'(kp.dato_listo_o), 0);
    check("reset_codc", int'(kp.dato_codc_o), 0);
    check("reset_codf", int'(kp.dato_codf_o), 0);
    check("reset_held", int'(kp.key_held_o), 0);

    // Idle scan: every column held SCAN_DIV cycles, wrapping.
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle_col[%0d]", i), int'(kp.col_o), int'(idle_col[i]));
      step();
    end

    // Clean presses from the table.
    for (int t = 0; t < 4; t++) begin
      n0 = ts_q.size();
      key_c[0]  = presses[t].c;
      key_r[0]  = presses[t].r;
      key_dn[0] = 1'b1;
      wait_pulse(200, ok);
      check($sformatf("press%0d_seen", t), int'(ok), 1);
      check($sformatf("press%0d_codc", t), int'(kp.dato_codc_o), int'(presses[t].exp_c));
      check($sformatf("press%0d_codf", t), int'(kp.dato_codf_o), int'(presses[t].exp_r));
      step();
      check($sformatf("press%0d_width", t), int'(kp.dato_listo_o), 0);
      check($sformatf("press%0d_held", t), int'(kp.key_held_o), 1);
      repeat (3) step();
      key_dn[0] = 1'b0;
      wait_release(100, ok);
      check($sformatf("press%0d_release", t), int'(ok), 1);
      check($sformatf("press%0d_col_after", t), int'(kp.col_o), int'(presses[t].exp_col_after));
      check($sformatf("press%0d_pulses", t), ts_q.size() - n0, 1);
      repeat (5) step();
    end

    // Bounce on (col 0,row 1): no pulse, then a steady hold gives exactly one.
    n0 = ts_q.size();
    key_c[0] = 2'd0;
    key_r[0] = 2'd1;
    for (int i = 0; i < 40; i++) begin
      key_dn[0] = ((i / 3) % 2) == 0;
      step();
    end
    key_dn[0] = 1'b0;
    repeat (3) step();
    check("bounce_no_pulse", ts_q.size() - n0, 0);
    key_dn[0] = 1'b1;
    wait_pulse(60, ok);
    check("bounce_hold_seen", int'(ok), 1);
    check("bounce_codc", int'(kp.dato_codc_o), 0);
    check("bounce_codf", int'(kp.dato_codf_o), 1);
    repeat (10) step();
    key_dn[0] = 1'b0;
    wait_release(100, ok);
    check("bounce_release", int'(ok), 1);
    check("bounce_pulses", ts_q.size() - n0, 1);

    // Two keys on column 1: ghosting is rejected and scanning continues.
    n0 = ts_q.size();
    key_c[0] = 2'd1; key_r[0] = 2'd0; key_dn[0] = 1'b1;
    key_c[1] = 2'd1; key_r[1] = 2'd1; key_dn[1] = 1'b1;
    seen = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      step();
      seen = seen | ~kp.col_o;
    end
    check("multi_no_pulse", ts_q.size() - n0, 0);
    check("multi_scan_all_cols", int'(seen), 4'hF);

    // Single key on column 1, then reset while it is being debounced.
    key_dn[1] = 1'b0;
    run = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      run = (kp.col_o == 4'b1101) ? run + 1 : 0;
      if (run >= 6) ok = 1'b1;
    end
    check("debounce_reached", int'(ok), 1);
    rst = 1'b0;
    step();
    check("midreset_col", int'(kp.col_o), 4'b1110);
    check("midreset_listo", int'(kp.dato_listo_o), 0);
    check("midreset_held", int'(kp.key_held_o), 0);
    check("midreset_codc", int'(kp.dato_codc_o), 0);
    check("midreset_codf", int'(kp.dato_codf_o), 0);
    key_dn[0] = 1'b0;
    rst = 1'b1;
    repeat (30) step();
    check("midreset_no_pulse", ts_q.size() - n0, 0);

    // Long hold on (col 3,row 0): auto-repeat pulses only when enabled.
    n0 = ts_q.size();
    key_c[0] = 2'd3; key_r[0] = 2'd0; key_dn[0] = 1'b1;
    wait_pulse(200, ok);
    check("hold_seen", int'(ok), 1);
    repeat (100) step();
    key_dn[0] = 1'b0;
    wait_release(100, ok);
    check("hold_release", int'(ok), 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_pulses", ts_q.size() - n0, 4);
    if (ts_q.size() - n0 == 4) begin
      for (int i = 1; i < 4; i++) begin
        check($sformatf("repeat%0d_gap", i), ts_q[n0+i] - ts_q[n0], 32 * i);
        check($sformatf("repeat%0d_codc", i), int'(pc_q[n0+i]), 3);
        check($sformatf("repeat%0d_codf", i), int'(pr_q[n0+i]), 0);
      end
    end
`else
    check("hold_pulses", ts_q.size() - n0, 1);
`endif
    if (ts_q.size() > n0) begin
      check("hold_codc", int'(pc_q[n0]), 3);
      check("hold_codf", int'(pr_q[n0]), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
